// File: rtl/avmm_mem_responder.sv
// avmm_mem_responder: Avalon-MM 16-bit RAM responder with programmable wait-states,
// fixed pipelined read latency, sticky error flags and transaction counters.
module avmm_mem_responder #(
    parameter int          ADDR_BITS    = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          WAIT_CYCLES  = 2,
    parameter int          READ_LATENCY = 3,
    parameter              INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_address,
    input  logic [15:0] avs_s0_writedata,
    input  logic [1:0]  avs_s0_byteenable,
    output logic        avs_s0_waitrequest,
    output logic [15:0] avs_s0_readdata,
    output logic        avs_s0_readdatavalid,
    input  logic        err_clear,
    output logic        err_unaligned,
    output logic        err_range,
    output logic        err_proto,
    output logic [31:0] wr_count,
    output logic [31:0] rd_count
);
    localparam int          DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0]  WAIT_N  = 4'(WAIT_CYCLES);
    localparam logic [30:0] DEPTH_W = 31'(DEPTH);

    logic [15:0]          mem [DEPTH];
    logic [3:0]           wcnt;
    logic                 req;
    logic                 accept;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [31:0]          off;
    logic                 in_range;
    logic                 unaligned;
    logic                 bad;
    logic [ADDR_BITS-1:0] idx;
    logic [15:0]          rd_word;
    logic                 pv [READ_LATENCY];
    logic [15:0]          pd [READ_LATENCY];

    assign req                = avs_s0_read | avs_s0_write;
    assign avs_s0_waitrequest = req && (wcnt < WAIT_N);
    assign accept             = req && !avs_s0_waitrequest;
    assign wr_acc             = accept && avs_s0_write;
    // A simultaneous read+write is served as a write only.
    assign rd_acc             = accept && avs_s0_read && !avs_s0_write;

    assign off       = avs_s0_address - BASE_ADDR;
    assign in_range  = (avs_s0_address >= BASE_ADDR) && (off[31:1] < DEPTH_W);
    assign unaligned = off[0];
    assign bad       = !in_range || unaligned;
    assign idx       = off[ADDR_BITS:1];
    assign rd_word   = bad ? 16'hDEAD : mem[idx];

    always_ff @(posedge clk) begin
        if (wr_acc && !bad) begin
            if (avs_s0_byteenable[0]) mem[idx][7:0]  <= avs_s0_writedata[7:0];
            if (avs_s0_byteenable[1]) mem[idx][15:8] <= avs_s0_writedata[15:8];
        end
    end

    // Data only advances with its valid bit, so the last stage holds the
    // most recently delivered word while no response is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= 16'h0;
            end
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc) pd[0] <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) pd[i] <= pd[i-1];
            end
        end
    end

    assign avs_s0_readdatavalid = pv[READ_LATENCY-1];
    assign avs_s0_readdata      = pd[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt          <= 4'd0;
            err_unaligned <= 1'b0;
            err_range     <= 1'b0;
            err_proto     <= 1'b0;
            wr_count      <= 32'd0;
            rd_count      <= 32'd0;
        end else begin
            wcnt <= (req && avs_s0_waitrequest) ? wcnt + 4'd1 : 4'd0;

            if (err_clear)               err_unaligned <= 1'b0;
            else if (accept && unaligned) err_unaligned <= 1'b1;

            if (err_clear)              err_range <= 1'b0;
            else if (accept && !in_range) err_range <= 1'b1;

            if (err_clear)                        err_proto <= 1'b0;
            else if (avs_s0_read && avs_s0_write) err_proto <= 1'b1;

            if (wr_acc) wr_count <= wr_count + 32'd1;
            if (rd_acc) rd_count <= rd_count + 32'd1;
        end
    end
endmodule
